framebuffer_writer: RTL and testbench

// - Write side of the double-buffered 320x240, 3-bit palette-index framebuffer; the scan-out reader is the other end.
// - Accepts (screenXY, color) pixels from the rasterizer over valid/ready and drives the framebuffer write port.
// - Clears the back buffer to index 0 before each frame is drawn.
// - Swaps front/back buffers only on the new_frame pulse, so scan-out never shows a partly drawn frame.

---
 rtl/framebuffer_writer_pkg.sv | 25 ++
 rtl/framebuffer_writer_fb_addr_calc.sv | 22 ++
 rtl/framebuffer_writer.sv | 125 ++++++++++++
 tb/tb_framebuffer_writer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/framebuffer_writer_pkg.sv
// Shared types for the framebuffer write side: screen coordinates, geometry constants, writer FSM states.
`default_nettype none

package framebuffer_writer_pkg;

    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int FB_AW     = 17;
    localparam int FB_PIXELS = FB_W * FB_H;

    // screenXY: x occupies bits [8:0], y occupies bits [16:9]
    typedef struct packed {
        logic [7:0] y;
        logic [8:0] x;
    } screen_xy_t;

    typedef enum logic [1:0] {
        CLEAR     = 2'd0,
        DRAW      = 2'd1,
        WAIT_SWAP = 2'd2
    } fbw_state_t;

endpackage

`default_nettype wire

// File: rtl/framebuffer_writer_fb_addr_calc.sv
// fb_addr_calc: combinational screenXY -> y*320+x linear address using shift-add (no multiplier).
`default_nettype none

module fb_addr_calc
    import framebuffer_writer_pkg::*;
(
    input  screen_xy_t       coords,
    output logic [FB_AW-1:0] addr
);

    logic [FB_AW-1:0] y_ext;
    logic [FB_AW-1:0] x_ext;

    assign y_ext = {{(FB_AW-8){1'b0}}, coords.y};
    assign x_ext = {{(FB_AW-9){1'b0}}, coords.x};

    // y*320 = y*256 + y*64
    assign addr = (y_ext << 8) + (y_ext << 6) + x_ext;

endmodule

`default_nettype wire

// File: rtl/framebuffer_writer.sv
// framebuffer_writer: clears the back buffer, writes rasterizer pixels, swaps buffers on new_frame.
// Optional macro FB_CLIP_EN: drop off-screen pixels and expose drop_count.
`default_nettype none

module framebuffer_writer
    import framebuffer_writer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_frame,
    input  logic               frame_done,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [16:0]        pix_coords,
    input  logic [2:0]         pix_color,
    output logic               fb_we,
    output logic [FB_AW:0]     fb_addr,
    output logic [2:0]         fb_data,
    output logic               front_buf,
    output logic               busy,
    output logic               swap_pending
`ifdef FB_CLIP_EN
    ,
    output logic [15:0]        drop_count
`endif
);

    localparam logic [FB_AW-1:0] CLR_END = FB_AW'(FB_PIXELS);

    fbw_state_t       state;
    logic [FB_AW-1:0] clr_cnt;
    logic [FB_AW-1:0] pix_addr;
    logic             handshake;
    logic             write_pix;
    screen_xy_t       coords;

    assign coords    = screen_xy_t'(pix_coords);
    assign handshake = pix_valid & pix_ready;

    fb_addr_calc u_addr_calc (
        .coords (coords),
        .addr   (pix_addr)
    );

`ifdef FB_CLIP_EN
    logic in_range;
    logic drop_pix;
    assign in_range  = (coords.x < 9'(FB_W)) && (coords.y < 8'(FB_H));
    assign write_pix = handshake & in_range;
    assign drop_pix  = handshake & ~in_range;
`else
    assign write_pix = handshake;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CLEAR;
            clr_cnt      <= '0;
            fb_we        <= 1'b0;
            fb_addr      <= '0;
            fb_data      <= '0;
            front_buf    <= 1'b0;
            pix_ready    <= 1'b0;
            busy         <= 1'b1;
            swap_pending <= 1'b0;
`ifdef FB_CLIP_EN
            drop_count   <= '0;
`endif
        end else begin
            case (state)
                CLEAR: begin
                    // Counter runs one past the last address so the final write is visible before DRAW
                    if (clr_cnt == CLR_END) begin
                        state     <= DRAW;
                        clr_cnt   <= '0;
                        fb_we     <= 1'b0;
                        pix_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        fb_we   <= 1'b1;
                        fb_addr <= {~front_buf, clr_cnt};
                        fb_data <= '0;
                        clr_cnt <= clr_cnt + FB_AW'(1);
                    end
                end
                DRAW: begin
                    fb_we <= write_pix;
                    if (write_pix) begin
                        fb_addr <= {~front_buf, pix_addr};
                        fb_data <= pix_color;
                    end
`ifdef FB_CLIP_EN
                    if (drop_pix && (drop_count != 16'hFFFF)) begin
                        drop_count <= drop_count + 16'd1;
                    end
`endif
                    if (frame_done) begin
                        state        <= WAIT_SWAP;
                        pix_ready    <= 1'b0;
                        swap_pending <= 1'b1;
                    end
                end
                WAIT_SWAP: begin
                    fb_we <= 1'b0;
                    if (new_frame) begin
                        front_buf    <= ~front_buf;
                        state        <= CLEAR;
                        busy         <= 1'b1;
                        swap_pending <= 1'b0;
`ifdef FB_CLIP_EN
                        drop_count   <= '0;
`endif
                    end
                end
                default: begin
                    state <= CLEAR;
                    fb_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_framebuffer_writer.sv
// tb_framebuffer_writer: randomized pixel traffic against a behavioural reference model of framebuffer_writer.
`default_nettype none

module tb_framebuffer_writer;

    localparam int W   = 320;
    localparam int H   = 240;
    localparam int PIX = W * H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        new_frame, frame_done, pix_valid, pix_ready;
    logic [16:0] pix_coords;
    logic [2:0]  pix_color;
    logic        fb_we;
    logic [17:0] fb_addr;
    logic [2:0]  fb_data;
    logic        front_buf, busy, swap_pending;
`ifdef FB_CLIP_EN
    logic [15:0] drop_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    framebuffer_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .new_frame    (new_frame),
        .frame_done   (frame_done),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_coords   (pix_coords),
        .pix_color    (pix_color),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .front_buf    (front_buf),
        .busy         (busy),
        .swap_pending (swap_pending)
`ifdef FB_CLIP_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = clearing, 1 = drawing, 2 = waiting for swap
    int          m_mode, m_cnt, m_x, m_y;
    bit          m_front;
    bit          e_we, e_ready, e_busy, e_pend;
    logic [17:0] e_addr;
    logic [2:0]  e_data;
    int          e_drop;
    bit          clip_en;

    initial begin
`ifdef FB_CLIP_EN
        clip_en = 1'b1;
`else
        clip_en = 1'b0;
`endif
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_front = 0;
            e_we = 0; e_addr = '0; e_data = '0;
            e_ready = 0; e_busy = 1; e_pend = 0; e_drop = 0;
        end else begin
            e_we = 0;
            if (m_mode == 0) begin
                if (m_cnt < PIX) begin
                    e_we   = 1;
                    e_addr = (18'(!m_front) << 17) + 18'(m_cnt);
                    e_data = 0;
                    m_cnt++;
                end else begin
                    m_mode = 1; m_cnt = 0; e_ready = 1; e_busy = 0;
                end
            end else if (m_mode == 1) begin
                if (pix_valid) begin
                    m_x = int'(pix_coords[8:0]);
                    m_y = int'(pix_coords[16:9]);
                    if (clip_en && (m_x >= W || m_y >= H)) begin
                        if (e_drop < 65535) e_drop++;
                    end else begin
                        e_we   = 1;
                        e_addr = (18'(!m_front) << 17) + 18'(m_y * W + m_x);
                        e_data = pix_color;
                    end
                end
                if (frame_done) begin
                    m_mode = 2; e_ready = 0; e_pend = 1;
                end
            end else begin
                if (new_frame) begin
                    m_front = !m_front; m_mode = 0; e_busy = 1; e_pend = 0; e_drop = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("fb_we", 32'(fb_we), 32'(e_we));
        chk("pix_ready", 32'(pix_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("swap_pending", 32'(swap_pending), 32'(e_pend));
        chk("front_buf", 32'(front_buf), 32'(m_front));
        if (e_we) begin
            chk("fb_addr", 32'(fb_addr), 32'(e_addr));
            chk("fb_data", 32'(fb_data), 32'(e_data));
        end
        if (!rst_n) begin
            chk("rst_fb_addr", 32'(fb_addr), 32'd0);
            chk("rst_fb_data", 32'(fb_data), 32'd0);
        end
`ifdef FB_CLIP_EN
        chk("drop_count", 32'(drop_count), 32'(e_drop));
`endif
    end

    function automatic logic [16:0] rnd_xy(input bit allow_oob);
        logic [8:0] x;
        logic [7:0] y;
        x = 9'($urandom_range(0, W - 1));
        y = 8'($urandom_range(0, H - 1));
        if (allow_oob && $urandom_range(0, 7) == 0) x = 9'($urandom_range(W, 511));
        if (allow_oob && $urandom_range(0, 7) == 0) y = 8'($urandom_range(H, 255));
        return {y, x};
    endfunction

    task automatic send_px(input logic [16:0] c, input logic [2:0] col);
        pix_valid = 1'b1; pix_coords = c; pix_color = col;
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    int          n_wr;
    int          budget;
    logic [17:0] first_a, last_a;

    initial begin
        rst_n = 1'b0; new_frame = 0; frame_done = 0; pix_valid = 0;
        pix_coords = '0; pix_color = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ready", 32'(pix_ready), 32'd0);
        rst_n = 1'b1;

        // Partial clear, then asynchronous reset around the 1000th write
        n_wr = 0; budget = 0;
        while (n_wr < 1000 && budget < 2000) begin
            @(negedge clk); budget++;
            if (fb_we) begin
                if (n_wr == 0) chk("first_clear_addr", 32'(fb_addr), 32'h20000);
                n_wr++;
            end
        end
        chk("partial_clear_reached", 32'(n_wr), 32'd1000);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", 32'(fb_we), 32'd0);
        chk("async_rst_addr", 32'(fb_addr), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full clear of buffer 1 after reset release
        n_wr = 0; budget = 0; first_a = '1; last_a = '0;
        while (budget < 80000) begin
            @(negedge clk); budget++;
            if (fb_we) begin
                if (n_wr == 0) first_a = fb_addr;
                last_a = fb_addr;
                n_wr++;
            end
            if (!busy) break;
        end
        chk("clear_write_count", 32'(n_wr), 32'd76800);
        chk("clear_first_addr", 32'(first_a), 32'h20000);
        chk("clear_last_addr", 32'(last_a), 32'h32BFF);
        chk("draw_ready", 32'(pix_ready), 32'd1);
        @(posedge clk); #1;

        // Corner pixel
        send_px({8'd239, 9'd319}, 3'd5);
        @(negedge clk);
        chk("corner_we", 32'(fb_we), 32'd1);
        chk("corner_addr", 32'(fb_addr), 32'h32BFF);
        chk("corner_data", 32'(fb_data), 32'd5);
        @(posedge clk); #1;

        // Four back-to-back pixels
        for (int i = 0; i < 4; i++) begin
            pix_valid = 1'b1; pix_coords = rnd_xy(1'b0); pix_color = 3'($urandom);
            @(negedge clk);
            if (i > 0) chk("b2b_we", 32'(fb_we), 32'd1);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        @(negedge clk);
        chk("b2b_we_last", 32'(fb_we), 32'd1);
        @(posedge clk); #1;

        // Off-screen coordinates
        send_px({8'd0, 9'd320}, 3'd3);
        @(negedge clk);
`ifdef FB_CLIP_EN
        chk("clip_x_we", 32'(fb_we), 32'd0);
`else
        chk("noclip_x_addr", 32'(fb_addr), 32'h20140);
`endif
        @(posedge clk); #1;
        send_px({8'd240, 9'd0}, 3'd4);
        @(negedge clk);
`ifdef FB_CLIP_EN
        chk("clip_y_we", 32'(fb_we), 32'd0);
        chk("clip_drop_count", 32'(drop_count), 32'd2);
`else
        chk("noclip_y_addr", 32'(fb_addr), 32'h32C00);
`endif
        @(posedge clk); #1;

        // Random traffic, with new_frame pulses that must be ignored while drawing
        for (int i = 0; i < 300; i++) begin
            pix_valid  = 1'($urandom);
            pix_coords = rnd_xy(1'b1);
            pix_color  = 3'($urandom);
            new_frame  = ($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
        end
        pix_valid = 0; new_frame = 0;

        // frame_done + pixel + new_frame in the same cycle: pixel written, no swap yet
        pix_valid = 1; pix_coords = {8'd20, 9'd10}; pix_color = 3'd0;
        frame_done = 1; new_frame = 1;
        @(posedge clk); #1;
        pix_valid = 0; frame_done = 0; new_frame = 0;
        @(negedge clk);
        chk("fd_pix_we", 32'(fb_we), 32'd1);
        chk("fd_pix_addr", 32'(fb_addr), 32'h2190A);
        chk("fd_ready", 32'(pix_ready), 32'd0);
        chk("fd_pending", 32'(swap_pending), 32'd1);
        chk("fd_front", 32'(front_buf), 32'd0);

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pix_valid = 1'($urandom); pix_coords = rnd_xy(1'b1);
        end
        pix_valid = 0;
        new_frame = 1;
        @(posedge clk); #1;
        new_frame = 0;
        @(negedge clk);
        chk("swap_front", 32'(front_buf), 32'd1);
        chk("swap_busy", 32'(busy), 32'd1);
`ifdef FB_CLIP_EN
        chk("swap_drop_cleared", 32'(drop_count), 32'd0);
`endif
        @(negedge clk);
        chk("swap_clear_addr", 32'(fb_addr), 32'h00000);

        // Clear of the old front buffer, new_frame pulses ignored
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            new_frame = ($urandom_range(0, 15) == 0);
        end
        new_frame = 0;
        @(negedge clk);
        chk("clear_front_stable", 32'(front_buf), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
